// File: rtl/uart_pkg.sv
// Shared UART transmitter types and constants.
// Holds the FSM state enum, frame-length constants and default bit timing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam int DATA_BITS        = 8;
  localparam int FRAME_BITS       = 10;
  localparam int CLKS_PER_BIT_DEF = 868;

endpackage

// File: rtl/baud_tick_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1, tick on the last count.
// Ports: clk, reset (sync, high), clear (restart at 0), tick (out).
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter fed by a first-word-fall-through FIFO.
// Ports: clk, reset, empty, rd_data[7:0] in; read, tx, tx_busy out.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       empty,
  input  logic [7:0] rd_data,
  output logic       read,
  output logic       tx,
  output logic       tx_busy
);

  state_e     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       parity_q, parity_d;
  logic       tx_q, tx_d;
  logic       tick;
  logic       clear;

  // Pop on idle, or on the last stop-bit cycle so frames run back to back.
  assign read = !reset && !empty &&
                ((state_q == IDLE) ||
                 ((state_q == STOP) && tick));

  // Counter held at zero while idle so every frame starts aligned.
  assign clear = (state_q == IDLE) || read;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    if (read) begin
      state_d   = START;
      shreg_d   = rd_data;
      parity_d  = ^rd_data;
      bit_cnt_d = '0;
      tx_d      = 1'b0;
    end else if (tick) begin
      unique case (state_q)
        START: begin
          state_d   = DATA;
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = '0;
        end
        DATA: begin
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            if (PARITY_EN) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end
        end
        PARITY: begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
        STOP: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three instances (4/no parity,
// 4/even parity, 868/no parity) share stimulus; one is observed at a time.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       empty;
  logic [7:0] rd_data;
  logic       read0, tx0, busy0;
  logic       read1, tx1, busy1;
  logic       read2, tx2, busy2;
  logic       read_o, tx_o, busy_o;
  int         sel;
  int         cyc;
  int         checks;
  int         errors;
  logic       exp_q[$];
  logic [7:0] stim_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) u0 (
    .clk(clk), .reset(reset), .empty(empty), .rd_data(rd_data),
    .read(read0), .tx(tx0), .tx_busy(busy0));

  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u1 (
    .clk(clk), .reset(reset), .empty(empty), .rd_data(rd_data),
    .read(read1), .tx(tx1), .tx_busy(busy1));

  uart_tx #(.CLKS_PER_BIT(868), .PARITY_EN(1'b0)) u2 (
    .clk(clk), .reset(reset), .empty(empty), .rd_data(rd_data),
    .read(read2), .tx(tx2), .tx_busy(busy2));

  always_comb begin
    read_o = read0;
    tx_o   = tx0;
    busy_o = busy0;
    case (sel)
      1: begin read_o = read1; tx_o = tx1; busy_o = busy1; end
      2: begin read_o = read2; tx_o = tx2; busy_o = busy2; end
      default: ;
    endcase
  end

  task automatic do_reset();
    reset   = 1'b1;
    empty   = 1'b1;
    rd_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Drives stim_q through the observed DUT, scoring tx sample by sample.
  task automatic stream(input int cpb, input int par,
                        output int pops, output int t0, output int t1);
    int   budget;
    int   idle;
    logic e;
    exp_q.delete();
    pops   = 0;
    t0     = -1;
    t1     = -1;
    idle   = 0;
    budget = (stim_q.size() + 1) * 11 * cpb + 20;
    if (stim_q.size() > 0) begin
      empty   = 1'b0;
      rd_data = stim_q.pop_front();
    end else begin
      empty = 1'b1;
    end
    while (budget > 0 && idle < 3) begin
      @(negedge clk);
      budget--;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (tx_o !== e)
          $display("FAIL tx_bit cyc=%0d got %b want %b", cyc, tx_o, e);
        if (tx_o !== e) errors++;
        checks++;
        if (busy_o !== 1'b1) begin
          $display("FAIL busy_frame cyc=%0d got %b want 1", cyc, busy_o);
          errors++;
        end
      end else begin
        checks++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
          $display("FAIL idle_line cyc=%0d got tx=%b busy=%b want 1/0",
                   cyc, tx_o, busy_o);
          errors++;
        end
      end
      if (read_o === 1'b1) begin
        checks++;
        if (empty !== 1'b0 || exp_q.size() != 0) begin
          $display("FAIL spurious_read cyc=%0d got read=1 want 0", cyc);
          errors++;
        end
        for (int k = 0; k < cpb; k++) exp_q.push_back(1'b0);
        for (int b = 0; b < 8; b++)
          for (int k = 0; k < cpb; k++) exp_q.push_back(rd_data[b]);
        if (par != 0)
          for (int k = 0; k < cpb; k++) exp_q.push_back(^rd_data);
        for (int k = 0; k < cpb; k++) exp_q.push_back(1'b1);
        if (pops == 0) t0 = cyc;
        else if (pops == 1) t1 = cyc;
        pops++;
        @(posedge clk);
        #1;
        if (stim_q.size() > 0) begin
          rd_data = stim_q.pop_front();
        end else begin
          empty   = 1'b1;
          rd_data = 8'($urandom);
        end
      end else if (empty && exp_q.size() == 0) begin
        idle++;
      end else if (empty) begin
        rd_data = 8'($urandom);
      end
    end
    checks++;
    if (budget == 0 || exp_q.size() != 0) begin
      $display("FAIL stream_timeout got %0d pending want 0", exp_q.size());
      errors++;
    end
  endtask

  task automatic test_reset();
    sel     = 0;
    reset   = 1'b1;
    empty   = 1'b0;
    rd_data = 8'h4B;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (read_o !== 1'b0 || tx_o !== 1'b1 || busy_o !== 1'b0) begin
        $display("FAIL reset_hold got read=%b tx=%b busy=%b want 0/1/0",
                 read_o, tx_o, busy_o);
        errors++;
      end
    end
  endtask

  task automatic test_single();
    int pops, t0, t1, rel;
    sel = 0;
    stim_q.delete();
    stim_q.push_back(8'h4B);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rel   = cyc;
    stream(4, 0, pops, t0, t1);
    checks++;
    if (pops != 1) begin
      $display("FAIL single_pops got %0d want 1", pops);
      errors++;
    end
    checks++;
    if (t0 != rel) begin
      $display("FAIL first_pop_cycle got %0d want %0d", t0, rel);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    int pops, t0, t1;
    sel = 0;
    do_reset();
    stim_q.delete();
    stim_q.push_back(8'h4B);
    stim_q.push_back(8'h20);
    for (int i = 0; i < 3; i++) stim_q.push_back(8'($urandom));
    reset = 1'b0;
    stream(4, 0, pops, t0, t1);
    checks++;
    if (pops != 5) begin
      $display("FAIL b2b_pops got %0d want 5", pops);
      errors++;
    end
    checks++;
    if (t1 - t0 != 40) begin
      $display("FAIL b2b_period got %0d want 40", t1 - t0);
      errors++;
    end
  endtask

  task automatic test_reset_midframe();
    int pops, t0, t1, rel, n;
    sel = 0;
    do_reset();
    empty   = 1'b0;
    rd_data = 8'h4B;
    reset   = 1'b0;
    n = 0;
    @(negedge clk);
    while (read_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (read_o !== 1'b1) begin
      $display("FAIL mid_first_pop got %b want 1", read_o);
      errors++;
    end
    @(posedge clk);
    #1;
    rd_data = 8'h0E;
    repeat (17) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (read_o !== 1'b0) begin
      $display("FAIL mid_no_pop got %b want 0", read_o);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || read_o !== 1'b0) begin
      $display("FAIL mid_abort got tx=%b busy=%b read=%b want 1/0/0",
               tx_o, busy_o, read_o);
      errors++;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    rel   = cyc;
    stim_q.delete();
    stim_q.push_back(8'h0E);
    stream(4, 0, pops, t0, t1);
    checks++;
    if (pops != 1 || t0 != rel) begin
      $display("FAIL mid_restart got pops=%0d t0=%0d want 1/%0d",
               pops, t0, rel);
      errors++;
    end
  endtask

  task automatic test_parity();
    int pops, t0, t1;
    sel = 1;
    do_reset();
    stim_q.delete();
    stim_q.push_back(8'h07);
    stim_q.push_back(8'h03);
    reset = 1'b0;
    stream(4, 1, pops, t0, t1);
    checks++;
    if (pops != 2 || t1 - t0 != 44) begin
      $display("FAIL parity_period got pops=%0d per=%0d want 2/44",
               pops, t1 - t0);
      errors++;
    end
  endtask

  task automatic test_slow_baud();
    int pops, t0, t1;
    sel = 2;
    do_reset();
    stim_q.delete();
    stim_q.push_back(8'h55);
    reset = 1'b0;
    stream(868, 0, pops, t0, t1);
    checks++;
    if (pops != 1) begin
      $display("FAIL slow_pops got %0d want 1", pops);
      errors++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sel    = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_midframe();
    test_parity();
    test_slow_baud();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
